// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: control-word bit indices,
// opcode values, sequencer state encoding and EXEC-phase classification.
package cpu_pkg;

  // Control-word bit positions (the ACC datapath uses CB_ACC_CLEAR as well)
  localparam int unsigned CB_PC_INC       = 0;
  localparam int unsigned CB_PC_LOAD      = 1;
  localparam int unsigned CB_MAR_FROM_PC  = 2;
  localparam int unsigned CB_MAR_FROM_IR  = 3;
  localparam int unsigned CB_MEM_READ     = 4;
  localparam int unsigned CB_MEM_WRITE    = 5;
  localparam int unsigned CB_MBR_TO_IR    = 6;
  localparam int unsigned CB_MBR_FROM_ACC = 7;
  localparam int unsigned CB_ALU_ADD      = 8;
  localparam int unsigned CB_ALU_SUB      = 9;
  localparam int unsigned CB_ACC_LOAD_MBR = 14;
  localparam int unsigned CB_ACC_LOAD_ALU = 15;
  localparam int unsigned CB_ACC_CLEAR    = 21;

  // Opcodes (IR[15:8])
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMP    = 8'h05;
  localparam logic [7:0] OP_JMPGEZ = 8'h06;
  localparam logic [7:0] OP_CLR    = 8'h07;
  localparam logic [7:0] OP_HALT   = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOADIR = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // How the EXEC state of an opcode terminates
  typedef enum logic [1:0] {
    EX_MEM_RD = 2'd0,  // wait for memory, then WB
    EX_MEM_WR = 2'd1,  // wait for memory, then FETCH
    EX_SINGLE = 2'd2,  // one cycle, then FETCH
    EX_HALT   = 2'd3   // one cycle, then HALT
  } exec_kind_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: (state, op_q, neg_q) -> control word.
// Ports:
//   state          sequencer state register
//   op_q           latched opcode
//   neg_q          latched ACC sign
//   control_signal datapath control word
//   illegal_op     high in EXEC for an undefined opcode
//   exec_kind      how EXEC for op_q terminates (used by the sequencer)
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int unsigned CW  = 32,
  parameter int unsigned OPW = 8
) (
  input  state_t           state,
  input  logic [OPW-1:0]   op_q,
  input  logic             neg_q,
  output logic [CW-1:0]    control_signal,
  output logic             illegal_op,
  output exec_kind_t       exec_kind
);

  function automatic logic [CW-1:0] cb(input int unsigned idx);
    return CW'(1) << idx;
  endfunction

  // Opcode classification for EXEC termination
  always_comb begin
    exec_kind = EX_SINGLE;
    case (op_q)
      OPW'(OP_LOAD), OPW'(OP_ADD), OPW'(OP_SUB): exec_kind = EX_MEM_RD;
      OPW'(OP_STORE):                            exec_kind = EX_MEM_WR;
      OPW'(OP_HALT):                             exec_kind = EX_HALT;
      default:                                   exec_kind = EX_SINGLE;
    endcase
  end

  // Moore control word
  always_comb begin
    control_signal = '0;
    illegal_op     = 1'b0;
    case (state)
      ST_FETCH:  control_signal = cb(CB_MAR_FROM_PC) | cb(CB_MEM_READ);
      ST_LOADIR: control_signal = cb(CB_MBR_TO_IR) | cb(CB_PC_INC);
      ST_EXEC: begin
        case (op_q)
          OPW'(OP_LOAD), OPW'(OP_ADD), OPW'(OP_SUB):
            control_signal = cb(CB_MAR_FROM_IR) | cb(CB_MEM_READ);
          OPW'(OP_STORE):
            control_signal = cb(CB_MAR_FROM_IR) | cb(CB_MBR_FROM_ACC) | cb(CB_MEM_WRITE);
          OPW'(OP_JMP):
            control_signal = cb(CB_PC_LOAD);
          OPW'(OP_JMPGEZ):
            control_signal = neg_q ? '0 : cb(CB_PC_LOAD);
          OPW'(OP_CLR):
            control_signal = cb(CB_ACC_CLEAR);
          OPW'(OP_HALT):
            control_signal = '0;
          default:
            illegal_op = 1'b1;
        endcase
      end
      ST_WB: begin
        case (op_q)
          OPW'(OP_LOAD): control_signal = cb(CB_ACC_LOAD_MBR);
          OPW'(OP_ADD):  control_signal = cb(CB_ALU_ADD) | cb(CB_ACC_LOAD_ALU);
          OPW'(OP_SUB):  control_signal = cb(CB_ALU_SUB) | cb(CB_ACC_LOAD_ALU);
          default:       control_signal = '0;
        endcase
      end
      default: control_signal = '0;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Accumulator-CPU instruction sequencer: fetch / decode / execute FSM that
// drives the datapath control word.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin execution (sampled in IDLE only)
//   ir_in           IR contents (opcode [15:8], address [7:0])
//   acc_neg         ACC sign bit
//   mem_ready       memory access completes at this edge
//   control_signal  datapath control word (decoded from registers only)
//   state_out       state encoding
//   busy            not IDLE and not HALT
//   halted          in HALT
//   illegal_op      EXEC of an undefined opcode
module acc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CW  = 32,
  parameter int unsigned OPW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   ir_in,
  input  logic          acc_neg,
  input  logic          mem_ready,
  output logic [CW-1:0] control_signal,
  output logic [2:0]    state_out,
  output logic          busy,
  output logic          halted,
  output logic          illegal_op
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           neg_q, neg_d;
  exec_kind_t     exec_kind;

  // Address field is consumed by the datapath, not the sequencer
  logic unused_addr;
  assign unused_addr = ^ir_in[7:0];

  // State, opcode and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state logic; opcode/flag capture happens only in DECODE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_LOADIR;
      ST_LOADIR: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = OPW'(ir_in[15:8]);
        neg_d   = acc_neg;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (exec_kind)
          EX_MEM_RD: if (mem_ready) state_d = ST_WB;
          EX_MEM_WR: if (mem_ready) state_d = ST_FETCH;
          EX_HALT:   state_d = ST_HALT;
          default:   state_d = ST_FETCH;
        endcase
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  ctrl_decode #(
    .CW  (CW),
    .OPW (OPW)
  ) u_ctrl_decode (
    .state          (state_q),
    .op_q           (op_q),
    .neg_q          (neg_q),
    .control_signal (control_signal),
    .illegal_op     (illegal_op),
    .exec_kind      (exec_kind)
  );

  assign state_out = state_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter CW, default 32, SHALL set the control-word width.
REQ-002 Parameter OPW, default 8, SHALL set the opcode width, taken from ir_in[15:8].
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  in  1  SHALL request program execution; it is sampled only in IDLE.
REQ-006 ir_in  in  16  SHALL carry the current IR contents (opcode [15:8], address [7:0]).
REQ-007 acc_neg  in  1  SHALL carry the ACC sign bit (acc_out[15]).
REQ-008 mem_ready  in  1  SHALL mean that the memory access requested this cycle completes at this edge.
REQ-009 control_signal  out  CW  SHALL carry the datapath control word.
REQ-010 state_out  out  3  SHALL expose the state encoding.
REQ-011 busy  out  1  SHALL be high when state is neither IDLE nor HALT.
REQ-012 halted  out  1  SHALL be high in HALT.
REQ-013 illegal_op  out  1  SHALL pulse for one cycle, in the EXEC cycle, when the opcode is undefined.

Function
REQ-014 The states SHALL be encoded IDLE=0, FETCH=1, LOADIR=2, DECODE=3, EXEC=4, WB=5, HALT=6.
REQ-015 control_signal SHALL be a Moore decode of the state register, the opcode register op_q and the flag register neg_q only, with no combinational path from any input.
REQ-016 Control bits SHALL be: 0 PC_INC, 1 PC_LOAD, 2 MAR_FROM_PC, 3 MAR_FROM_IR, 4 MEM_READ, 5 MEM_WRITE, 6 MBR_TO_IR, 7 MBR_FROM_ACC, 8 ALU_ADD, 9 ALU_SUB, 14 ACC_LOAD_MBR, 15 ACC_LOAD_ALU, 21 ACC_CLEAR; all other bits SHALL be 0.
REQ-017 Opcodes SHALL be: 0x01 LOAD, 0x02 STORE, 0x03 ADD, 0x04 SUB, 0x05 JMP, 0x06 JMPGEZ, 0x07 CLR, 0x0F HALT; every other value SHALL execute as a NOP with illegal_op asserted.
REQ-018 IDLE SHALL drive an all-zero control word, and SHALL go to FETCH when start=1.
REQ-019 FETCH SHALL assert MAR_FROM_PC|MEM_READ, hold while mem_ready=0, and go to LOADIR when mem_ready=1.
REQ-020 LOADIR SHALL assert MBR_TO_IR|PC_INC for exactly one cycle, then go to DECODE.
REQ-021 DECODE SHALL drive an all-zero control word, capture op_q<=ir_in[15:8] and neg_q<=acc_neg, then go to EXEC.
REQ-022 EXEC for LOAD, ADD and SUB SHALL assert MAR_FROM_IR|MEM_READ, hold until mem_ready=1, then go to WB.
REQ-023 EXEC for STORE SHALL assert MAR_FROM_IR|MBR_FROM_ACC|MEM_WRITE, hold until mem_ready=1, then go to FETCH.
REQ-024 EXEC for JMP SHALL assert PC_LOAD for one cycle, then go to FETCH.
REQ-025 EXEC for JMPGEZ SHALL assert PC_LOAD only if neg_q=0, then go to FETCH.
REQ-026 EXEC for CLR SHALL assert ACC_CLEAR (bit 21) for one cycle, then go to FETCH.
REQ-027 EXEC for HALT SHALL drive an all-zero control word, then go to HALT.
REQ-028 EXEC for an undefined opcode SHALL drive an all-zero control word, then go to FETCH.
REQ-029 WB SHALL assert ACC_LOAD_MBR for LOAD, ALU_ADD|ACC_LOAD_ALU for ADD and ALU_SUB|ACC_LOAD_ALU for SUB, for one cycle, then go to FETCH.
REQ-030 HALT SHALL be absorbing: the control word is zero and start is ignored; only rst exits HALT.
REQ-031 With mem_ready held at 1, the cycles per instruction SHALL be: LOAD/ADD/SUB 5; STORE/JMP/JMPGEZ/CLR/NOP 4; HALT 4 cycles to reach HALT.
REQ-032 mem_ready SHALL be ignored in every state except FETCH and memory-op EXEC.
REQ-033 MEM_READ and MEM_WRITE SHALL never be asserted in the same cycle.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, op_q=0 and neg_q=0 from any state, including a pending memory wait.
REQ-035 After reset: control_signal=0, state_out=0, busy=0, halted=0, illegal_op=0.
REQ-036 rst SHALL take priority over start and mem_ready at the same edge.

Structure
REQ-037 Package cpu_pkg SHALL hold the control-bit index constants, the opcode constants and the state enum; the ACC datapath SHALL use the same ACC_CLEAR index.
REQ-038 A sub-module ctrl_decode SHALL hold the combinational decode (state, op_q, neg_q) -> control_signal.
REQ-039 acc_sequencer SHALL hold the state, op_q and neg_q registers.

Verification
REQ-040 rst pulse, then start=1, ir_in=0x0110, mem_ready=1 -> states 1,2,3,4,5; WB word=0x0000_4000; back to FETCH.
REQ-041 STORE 0x0220 with mem_ready low for 3 cycles in EXEC -> word 0x0000_00A8 held for 4 cycles, then FETCH.
REQ-042 JMPGEZ with acc_neg=1 at DECODE -> EXEC word=0; with acc_neg=0 -> EXEC word=0x0000_0002.
REQ-043 CLR 0x0700 -> EXEC word=0x0020_0000 for exactly one cycle.
REQ-044 Opcode 0x3C -> illegal_op=1 for one cycle and word=0; opcode 0x0F -> halted=1, and a later start=1 does not change state.
REQ-045 rst=1 asserted in an EXEC memory wait -> next cycle state_out=0, control_signal=0, busy=0.
